// File: rtl/mc_ctrl_pkg.sv
// Shared codes for the multicycle RV32I control unit.
// State encoding, opcodes, ALU and mux select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from alu_op and the funct fields.
// opcode[5] separates R-type sub from I-type addi.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (1'b1)
      (alu_op == ALUOP_SUB): alu_control = ALU_SUB;
      (alu_op == ALUOP_FN): begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I subset control FSM and main decode.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on unsupported opcodes.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW   = 7,
  parameter int ALUCW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALUCW-1:0] alu_control,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic             illegal_instr
);

  state_t     state;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            (opcode == OP_LW),
            (opcode == OP_SW):  state <= S_MEMADR;
            (opcode == OP_R):   state <= S_EXECUTER;
            (opcode == OP_I):   state <= S_EXECUTEI;
            (opcode == OP_JAL): state <= S_JAL;
            (opcode == OP_BEQ): state <= S_BEQ;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            default:            state <= S_TRAP;
`else
            default:            state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_LW)
            state <= S_MEMREAD;
          else if (opcode == OP_SW)
            state <= S_MEMWRITE;
          else
            state <= S_FETCH;
        end
        S_MEMREAD:  state <= S_MEMWB;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_TRAP:     state <= S_TRAP;
`endif
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced to zero while rst is held, whatever the state.
  always_comb begin
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    reg_write  = 1'b0;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ir_write   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURES;
          pc_update  = 1'b1;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RD1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: adr_src = 1'b1;
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECUTER: begin
          alu_src_a = SRCA_RD1;
          alu_op    = ALUOP_FN;
        end
        S_EXECUTEI: begin
          alu_src_a = SRCA_RD1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_FN;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = SRCA_RD1;
          alu_op    = ALUOP_SUB;
          branch    = 1'b1;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_update = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_write = pc_update | (branch & zero);

  always_comb begin
    imm_src = IMM_I;
    if (!rst) begin
      unique case (1'b1)
        (opcode == OP_SW):  imm_src = IMM_S;
        (opcode == OP_BEQ): imm_src = IMM_B;
        (opcode == OP_JAL): imm_src = IMM_J;
        default:            imm_src = IMM_I;
      endcase
    end
  end

  logic [2:0] alu_ctl;

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (opcode[5]),
    .alu_control (alu_ctl)
  );

  assign alu_control = ALUCW'(alu_ctl);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit that sequences the shared PC / instruction-memory / register-file / extend / ALU datapath as a multicycle RV32I subset core.
- Handles lw, sw, R-type, I-type ALU, beq and jal.
- Moore FSM plus combinational ALU and immediate decode. Sits beside the datapath and drives every enable and mux select.
- One instruction completes every 3–5 cycles.

Parameters:
- OPW, 7, opcode width (fixed to the RV32I field).
- ALUCW, 3, width of alu_control.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register and OldPC enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU B mux: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  out  2  extend select: 00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  out  1  register file WE3.
- illegal_instr  out  1  sticky illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset: rst high at a clock edge forces state to FETCH. Reset mid-instruction abandons that instruction; no partial write follows.
- While rst is high, all enables (pc_write, mem_write, ir_write, reg_write) are 0 and all selects are 0.
- Outputs are functions of state, except two Mealy terms: pc_write includes branch&zero, and alu_control depends on funct fields.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw or sw -> MEMADR; R-type (0110011) -> EXECUTER; I-type (0010011) -> EXECUTEI; jal (1101111) -> JAL; beq (1100011) -> BEQ; any other opcode -> FETCH.
  - MEMADR: lw (0000011) -> MEMREAD; sw (0100011) -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - MEMWB, MEMWRITE and BEQ -> FETCH.
  - EXECUTER, EXECUTEI and JAL -> ALUWB.
  - ALUWB -> FETCH.
- Per-state outputs (unlisted signals are 0):
  - FETCH: ir_write=1, alu_src_b=10, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01 (branch target precompute).
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECUTER: alu_src_a=10, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: reg_write=1.
  - BEQ: alu_src_a=10, alu_op=01, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
- pc_write = pc_update | (branch & zero).
- ALU decode:
  - alu_op 00 -> add.
  - alu_op 01 -> sub.
  - alu_op 10 -> by funct3: 000 gives sub if opcode[5]&funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
- imm_src is combinational from opcode: sw -> 01, beq -> 10, jal -> 11, all others -> 00.
- Latency in cycles: lw 5; sw, R, I, jal 4; beq 3; unsupported opcode 2.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported opcode in DECODE goes to state TRAP.
  - TRAP holds all enables at 0 and self-loops until rst.
  - illegal_instr is 1 from the first TRAP cycle until reset.
- Undefined:
  - An unsupported opcode returns to FETCH (executes as a NOP).
  - illegal_instr is tied to 0.
  - The TRAP encoding is unused.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state encoding localparams (4-bit);
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - alu_op and alu_control codes;
  - the result, src and imm_src select codes.
- Sub-module alu_decoder: combinational mapping of alu_op, funct3, funct7b5 and opcode[5] to alu_control.
- The FSM and main decode stay in multicycle_control.

Test Plan:
- Reset: assert rst for 2 cycles mid-EXECUTER, then release -> state FETCH with ir_write=1 and pc_write=1 on the first cycle; no reg_write pulse in between.
- lw (0000011): expect states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 and result_src=01 only in cycle 5.
- sw (0100011): mem_write=1 and adr_src=1 only in cycle 4; imm_src=01; reg_write never 1.
- R-type sub (funct3=000, funct7b5=1): alu_control=001 in EXECUTER. Same instruction as I-type addi with funct7b5=1: alu_control=000.
- beq: zero=1 in BEQ -> pc_write=1; zero=0 -> pc_write=0; back in FETCH after 3 cycles.
- Opcode 1111111: with MC_CTRL_ILLEGAL_TRAP_EN, illegal_instr=1 and the FSM stays in TRAP for 10+ cycles; without it, returns to FETCH after 2 cycles with illegal_instr=0.
